// File: rtl/skew_delay_bank.sv
// rtl/skew_delay_bank.sv - multi-lane skew/deskew delay bank with valid tracking
module skew_delay_bank #(
  parameter int WIDTH      = 8,
  parameter int LANES      = 8,
  parameter int BASE_DELAY = 1,
  parameter int DESKEW     = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic [LANES*WIDTH-1:0] din,
  output logic [LANES*WIDTH-1:0] dout,
  output logic [LANES-1:0]       dout_valid,
  output logic                   busy
);

  logic [LANES-1:0] lane_busy;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    localparam int D = (DESKEW != 0) ? (BASE_DELAY + LANES - 1 - k) : (BASE_DELAY + k);

    logic [WIDTH-1:0] data [D];
    logic [D-1:0]     vld;

    always_ff @(posedge clk) begin
      if (rst || flush) begin
        for (int i = 0; i < D; i++) data[i] <= '0;
        vld <= '0;
      end else if (en) begin
        // Bubbles enter as zero so an invalid output word always reads 0.
        data[0] <= in_valid ? din[k*WIDTH +: WIDTH] : '0;
        vld[0]  <= in_valid;
        for (int i = 1; i < D; i++) begin
          data[i] <= data[i-1];
          vld[i]  <= vld[i-1];
        end
      end
    end

    assign dout[k*WIDTH +: WIDTH] = data[D-1];
    assign dout_valid[k]          = vld[D-1];
    assign lane_busy[k]           = |vld;
  end

  assign busy = |lane_busy;

endmodule

// File: tb/tb_skew_delay_bank.sv
// tb/tb_skew_delay_bank.sv - scoreboard bench for skew_delay_bank, skew and deskew instances
module tb_skew_delay_bank;
  localparam int W = 8;
  localparam int L = 4;
  localparam int B = 1;

  logic          clk = 1'b0;
  logic          rst, en, flush, in_valid;
  logic [L*W-1:0] din;
  logic [L*W-1:0] dout0, dout1;
  logic [L-1:0]   dv0, dv1;
  logic           busy0, busy1;

  always #5 clk = ~clk;

  skew_delay_bank #(.WIDTH(W), .LANES(L), .BASE_DELAY(B), .DESKEW(0)) u_skew (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .in_valid(in_valid),
    .din(din), .dout(dout0), .dout_valid(dv0), .busy(busy0));

  skew_delay_bank #(.WIDTH(W), .LANES(L), .BASE_DELAY(B), .DESKEW(1)) u_deskew (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .in_valid(in_valid),
    .din(din), .dout(dout1), .dout_valid(dv1), .busy(busy1));

  typedef struct packed {
    logic [7:0] val;
    int         due;
  } exp_t;

  exp_t     q [2][L][$];
  int       errors = 0;
  int       checks = 0;
  int       shift_cnt = 0;
  bit       last_shift = 0;
  bit       cleared = 0;
  bit       started = 0;
  logic [L*W-1:0] prev_dout [2];
  logic [L-1:0]   prev_dv [2];

  function automatic int dk(input int d, input int k);
    return (d != 0) ? (B + L - 1 - k) : (B + k);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Drive on the falling edge, then record what the rising edge should do.
  task automatic cyc(input logic r, input logic f, input logic e, input logic v,
                     input logic [L*W-1:0] d);
    exp_t x;
    @(negedge clk);
    rst = r; flush = f; en = e; in_valid = v; din = d;
    @(posedge clk);
    if (r || f) begin
      for (int dd = 0; dd < 2; dd++)
        for (int k = 0; k < L; k++) q[dd][k].delete();
      last_shift = 0;
      cleared = 1;
    end else if (e) begin
      shift_cnt++;
      last_shift = 1;
      cleared = 0;
      if (v) begin
        for (int dd = 0; dd < 2; dd++)
          for (int k = 0; k < L; k++) begin
            x.val = d[k*W +: W];
            x.due = shift_cnt + dk(dd, k) - 1;
            q[dd][k].push_back(x);
          end
      end
    end else begin
      last_shift = 0;
      cleared = 0;
    end
    started = 1;
  endtask

  always @(negedge clk) begin
    if (started) begin
      for (int dd = 0; dd < 2; dd++) begin
        logic [L*W-1:0] od;
        logic [L-1:0]   ov;
        logic           ob;
        logic           busy_exp;
        exp_t           x;
        od = (dd != 0) ? dout1 : dout0;
        ov = (dd != 0) ? dv1 : dv0;
        ob = (dd != 0) ? busy1 : busy0;
        busy_exp = 1'b0;
        for (int k = 0; k < L; k++) if (q[dd][k].size() != 0) busy_exp = 1'b1;
        if (cleared) begin
          chk($sformatf("clr_dout[%0d]", dd), od, '0);
          chk($sformatf("clr_valid[%0d]", dd), {28'd0, ov}, 32'd0);
          chk($sformatf("clr_busy[%0d]", dd), {31'd0, ob}, 32'd0);
        end else begin
          chk($sformatf("busy[%0d]@%0d", dd, shift_cnt), {31'd0, ob}, {31'd0, busy_exp});
          for (int k = 0; k < L; k++) begin
            if (!last_shift) begin
              chk($sformatf("stall_hold[%0d]lane%0d", dd, k),
                  {23'd0, ov[k], od[k*W +: W]}, {23'd0, prev_dv[dd][k], prev_dout[dd][k*W +: W]});
            end else if (ov[k]) begin
              if (q[dd][k].size() == 0) begin
                chk($sformatf("unexpected[%0d]lane%0d", dd, k), {23'd1, od[k*W +: W]}, 32'd0);
              end else begin
                x = q[dd][k].pop_front();
                chk($sformatf("data[%0d]lane%0d", dd, k), {24'd0, od[k*W +: W]}, {24'd0, x.val});
                chk($sformatf("time[%0d]lane%0d", dd, k), shift_cnt, x.due);
              end
            end else begin
              chk($sformatf("bubble_zero[%0d]lane%0d", dd, k), {24'd0, od[k*W +: W]}, 32'd0);
              if (q[dd][k].size() != 0 && q[dd][k][0].due <= shift_cnt) begin
                x = q[dd][k].pop_front();
                chk($sformatf("missing[%0d]lane%0d", dd, k), shift_cnt, x.due + 1000);
              end
            end
          end
        end
        prev_dout[dd] = od;
        prev_dv[dd]   = ov;
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; flush = 1'b0; in_valid = 1'b0; din = '0;
    cyc(1, 0, 0, 0, '0);
    cyc(1, 0, 0, 0, '0);

    // Single pulse: skew staircase on u_skew, reversed on u_deskew.
    cyc(0, 0, 1, 1, 32'h44332211);
    repeat (6) cyc(0, 0, 1, 0, '0);

    // Streaming with a two-cycle stall; din during the stall must be ignored.
    cyc(0, 0, 1, 1, 32'h01010101);
    cyc(0, 0, 1, 1, 32'h02020202);
    cyc(0, 0, 0, 1, 32'hDEADBEEF);
    cyc(0, 0, 0, 0, '0);
    cyc(0, 0, 1, 1, 32'h03030303);
    cyc(0, 0, 1, 1, 32'h04040404);
    repeat (6) cyc(0, 0, 1, 0, '0);

    // Flush with three words in flight; the flush-cycle word is discarded.
    cyc(0, 0, 1, 1, 32'h10101010);
    cyc(0, 0, 1, 1, 32'h20202020);
    cyc(0, 0, 1, 1, 32'h30303030);
    cyc(0, 1, 0, 1, 32'hEEEEEEEE);
    repeat (6) cyc(0, 0, 1, 0, '0);

    // Reset wins over en/in_valid; next word has nominal latency.
    cyc(0, 0, 1, 1, 32'h55555555);
    cyc(1, 0, 1, 1, 32'hFFFFFFFF);
    cyc(0, 0, 1, 1, 32'h0D0C0B0A);
    repeat (6) cyc(0, 0, 1, 0, '0);

    // Alternating bubbles with constant din.
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, (i % 2) == 0, 32'hAAAAAAAA);
    repeat (6) cyc(0, 0, 1, 0, '0);

    @(negedge clk);
    #1;
    for (int dd = 0; dd < 2; dd++)
      for (int k = 0; k < L; k++)
        chk($sformatf("drained[%0d]lane%0d", dd, k), q[dd][k].size(), 32'd0);
    chk("idle_busy", {30'd0, busy1, busy0}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
